// File: rtl/out_port_arbiter.sv
// rtl/out_port_arbiter.sv - wormhole round-robin arbiter for one NoC router output port
//
// Shares one output port among five input requesters (N, S, E, W, L). A packet
// owner is chosen round-robin while idle and keeps the port from head to tail.
// An optional watchdog releases an owner that stalls for TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT  stall cycles before a locked owner is forcibly released (0 = off)
//   CNT_W    width of the transferred-flit counter
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_i[4:0]  per-input request; bit0=N, 1=S, 2=E, 3=W, 4=L
//   tail_i[4:0] per-input tail marker; only the owner's bit is used
//   ready_i     downstream accepts a flit this cycle
//   sel_o[2:0]  mux select; 001=N, 010=S, 011=E, 100=W, 101=L, 111=none
//   valid_o     flit on the mux output is valid this cycle
//   pop_o[4:0]  one-hot dequeue strobe for the owner's input buffer
//   busy_o      port is locked to an owner
//   timeout_o   one-cycle pulse when the watchdog releases an owner
//   flit_cnt_o  wrapping count of transferred flits

module out_port_arbiter #(
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       req_i,
  input  logic [4:0]       tail_i,
  input  logic             ready_i,
  output logic [2:0]       sel_o,
  output logic             valid_o,
  output logic [4:0]       pop_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] flit_cnt_o
);

  localparam int ST_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Value of the stall counter during the last stalled cycle before release.
  localparam logic [ST_W-1:0] STALL_LAST = ST_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [2:0] SEL_NONE = 3'b111;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          state;
  logic [2:0]      owner;      // owner index 0..4
  logic [2:0]      rr_ptr;     // highest-priority index for the next arbitration
  logic [ST_W-1:0] stall_cnt;

  logic [4:0] owner_mask;
  logic       owner_req;
  logic       owner_tail;
  logic       xfer;
  logic       expire;
  logic [2:0] next_ptr;
  logic [2:0] pick;
  logic       pick_vld;

  assign owner_mask = 5'b00001 << owner;
  assign owner_req  = |(req_i & owner_mask);
  assign owner_tail = |(tail_i & owner_mask);
  assign valid_o    = (state == LOCKED) && owner_req;
  assign xfer       = valid_o && ready_i;
  assign pop_o      = xfer ? owner_mask : 5'b00000;
  assign next_ptr   = (owner == 3'd4) ? 3'd0 : owner + 3'd1;

  // A transfer always wins over watchdog expiry in the same cycle.
  assign expire = (TIMEOUT > 0) && (state == LOCKED) && !xfer && (stall_cnt == STALL_LAST);

  // Cyclic first-set scan starting at rr_ptr.
  always_comb begin
    logic [3:0] idx;
    pick     = 3'd0;
    pick_vld = 1'b0;
    idx      = 4'd0;
    for (int i = 0; i < 5; i++) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      if (idx > 4'd4) idx = idx - 4'd5;
      if (!pick_vld && req_i[idx[2:0]]) begin
        pick     = idx[2:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 3'd0;
      rr_ptr     <= 3'd0;
      stall_cnt  <= '0;
      sel_o      <= SEL_NONE;
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
      flit_cnt_o <= '0;
    end else begin
      timeout_o <= 1'b0;
      if (xfer) flit_cnt_o <= flit_cnt_o + 1'b1;

      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= LOCKED;
            owner     <= pick;
            sel_o     <= pick + 3'd1;
            busy_o    <= 1'b1;
            stall_cnt <= '0;
          end
        end

        LOCKED: begin
          if (xfer) begin
            stall_cnt <= '0;
            if (owner_tail) begin
              state  <= IDLE;
              sel_o  <= SEL_NONE;
              busy_o <= 1'b0;
              rr_ptr <= next_ptr;
            end
          end else if (expire) begin
            state     <= IDLE;
            sel_o     <= SEL_NONE;
            busy_o    <= 1'b0;
            rr_ptr    <= next_ptr;
            stall_cnt <= '0;
            timeout_o <= 1'b1;
          end else if (TIMEOUT > 0) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          sel_o  <= SEL_NONE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// tb/tb_out_port_arbiter.sv - self-checking bench for out_port_arbiter

module tb_out_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] req = '0;
  logic [4:0] tail = '0;
  logic       ready = 1'b0;

  logic [2:0]  sel_a, sel_b;
  logic        valid_a, valid_b;
  logic [4:0]  pop_a, pop_b;
  logic        busy_a, busy_b;
  logic        tmo_a, tmo_b;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Instance A: watchdog on, narrow counter. Instance B: watchdog off, default counter.
  out_port_arbiter #(.TIMEOUT(8), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req_i(req), .tail_i(tail), .ready_i(ready),
    .sel_o(sel_a), .valid_o(valid_a), .pop_o(pop_a), .busy_o(busy_a),
    .timeout_o(tmo_a), .flit_cnt_o(cnt_a)
  );

  out_port_arbiter #(.TIMEOUT(0), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .req_i(req), .tail_i(tail), .ready_i(ready),
    .sel_o(sel_b), .valid_o(valid_b), .pop_o(pop_b), .busy_o(busy_b),
    .timeout_o(tmo_b), .flit_cnt_o(cnt_b)
  );

  // Reference model: one record of port ownership per instance.
  int m_locked[2], m_owner[2], m_ptr[2], m_stall[2], m_cnt[2], m_tmo[2];
  int tmo_lim[2] = '{8, 0};
  int cnt_mod[2] = '{16, 65536};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_locked[k] = 0; m_owner[k] = 0; m_ptr[k] = 0;
      m_stall[k] = 0; m_cnt[k] = 0; m_tmo[k] = 0;
    end
  endtask

  task automatic compare_model();
    int a_sel[2], a_val[2], a_pop[2], a_busy[2], a_tmo[2], a_cnt[2];
    int e_val, e_pop;
    a_sel  = '{int'(sel_a), int'(sel_b)};
    a_val  = '{int'(valid_a), int'(valid_b)};
    a_pop  = '{int'(pop_a), int'(pop_b)};
    a_busy = '{int'(busy_a), int'(busy_b)};
    a_tmo  = '{int'(tmo_a), int'(tmo_b)};
    a_cnt  = '{int'(cnt_a), int'(cnt_b)};
    for (int k = 0; k < 2; k++) begin
      e_val = (m_locked[k] != 0 && req[m_owner[k]]) ? 1 : 0;
      e_pop = (e_val != 0 && ready) ? (1 << m_owner[k]) : 0;
      check($sformatf("model_sel[%0d]", k),   a_sel[k],  m_locked[k] != 0 ? m_owner[k] + 1 : 7);
      check($sformatf("model_valid[%0d]", k), a_val[k],  e_val);
      check($sformatf("model_pop[%0d]", k),   a_pop[k],  e_pop);
      check($sformatf("model_busy[%0d]", k),  a_busy[k], m_locked[k]);
      check($sformatf("model_tmo[%0d]", k),   a_tmo[k],  m_tmo[k]);
      check($sformatf("model_cnt[%0d]", k),   a_cnt[k],  m_cnt[k]);
    end
  endtask

  task automatic model_advance();
    int xfer, idx, found;
    for (int k = 0; k < 2; k++) begin
      m_tmo[k] = 0;
      if (m_locked[k] != 0) begin
        xfer = (req[m_owner[k]] && ready) ? 1 : 0;
        if (xfer != 0) begin
          m_cnt[k] = (m_cnt[k] + 1) % cnt_mod[k];
          m_stall[k] = 0;
          if (tail[m_owner[k]]) begin
            m_locked[k] = 0;
            m_ptr[k] = (m_owner[k] + 1) % 5;
          end
        end else if (tmo_lim[k] > 0) begin
          m_stall[k]++;
          if (m_stall[k] == tmo_lim[k]) begin
            m_locked[k] = 0;
            m_ptr[k] = (m_owner[k] + 1) % 5;
            m_tmo[k] = 1;
            m_stall[k] = 0;
          end
        end
      end else begin
        found = 0;
        for (int i = 0; i < 5; i++) begin
          idx = (m_ptr[k] + i) % 5;
          if (found == 0 && req[idx]) begin
            found = 1;
            m_owner[k] = idx;
            m_locked[k] = 1;
            m_stall[k] = 0;
          end
        end
      end
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check, then advance the model
  // for the coming rising edge. Outputs stay readable when the task returns.
  task automatic step(input logic [4:0] r, input logic [4:0] t, input logic rdy);
    @(negedge clk);
    req = r; tail = t; ready = rdy;
    #1;
    compare_model();
    model_advance();
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_sel_a", sel_a, 7);
    check("rst_busy_a", busy_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_pop_a", pop_a, 0);
    check("rst_tmo_a", tmo_a, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_sel_b", sel_b, 7);
    check("rst_cnt_b", cnt_b, 0);
    model_reset();
    req = '0; tail = '0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] req;
    logic [4:0] tail;
    logic       ready;
    logic [2:0] sel;
    logic       valid;
    logic [4:0] pop;
    logic       busy;
  } vec_t;

  vec_t vecs[5];
  int   k_hit;

  initial begin
    model_reset();

    // Three-flit packet from N.
    vecs[0] = '{5'b00001, 5'b00000, 1'b1, 3'b111, 1'b0, 5'b00000, 1'b0};
    vecs[1] = '{5'b00001, 5'b00000, 1'b1, 3'b001, 1'b1, 5'b00001, 1'b1};
    vecs[2] = '{5'b00001, 5'b00000, 1'b1, 3'b001, 1'b1, 5'b00001, 1'b1};
    vecs[3] = '{5'b00001, 5'b00001, 1'b1, 3'b001, 1'b1, 5'b00001, 1'b1};
    vecs[4] = '{5'b00000, 5'b00000, 1'b1, 3'b111, 1'b0, 5'b00000, 1'b0};

    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].req, vecs[i].tail, vecs[i].ready);
      check($sformatf("vec%0d_sel", i),   sel_a,   vecs[i].sel);
      check($sformatf("vec%0d_valid", i), valid_a, vecs[i].valid);
      check($sformatf("vec%0d_pop", i),   pop_a,   vecs[i].pop);
      check($sformatf("vec%0d_busy", i),  busy_a,  vecs[i].busy);
    end
    check("three_flit_cnt", cnt_a, 3);

    // All inputs requesting, single-flit packets: N,S,E,W,L,N with bubbles.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(5'b11111, 5'b11111, 1'b1);
      check($sformatf("rr_sel%0d", i), sel_a, (i % 2 == 0) ? 7 : ((i / 2) % 5) + 1);
    end

    // E owns the port and stalls while W requests.
    do_reset();
    step(5'b00100, 5'b00000, 1'b1);
    step(5'b01100, 5'b00000, 1'b1);
    check("e_head_pop", pop_a, 5'b00100);
    for (int i = 0; i < 4; i++) begin
      step(5'b01100, 5'b00000, 1'b0);
      check($sformatf("e_stall_sel%0d", i), sel_a, 3);
      check($sformatf("e_stall_pop%0d", i), pop_a, 0);
    end
    step(5'b01100, 5'b00100, 1'b1);
    check("e_tail_pop", pop_a, 5'b00100);
    step(5'b01000, 5'b00000, 1'b1);
    check("e_release_sel", sel_a, 7);

    // Watchdog: S drops its request after the head.
    do_reset();
    step(5'b00010, 5'b00000, 1'b1);
    step(5'b00010, 5'b00000, 1'b1);
    check("s_head_pop", pop_a, 5'b00010);
    k_hit = 0;
    for (int i = 1; i <= 20; i++) begin
      step(5'b00000, 5'b00000, 1'b1);
      if (k_hit == 0 && tmo_a) k_hit = i;
    end
    // Pulse is visible 8 edges after the transfer edge, i.e. on the 9th step.
    check("timeout_delay", k_hit, 9);
    do_reset();
    step(5'b00010, 5'b00000, 1'b1);
    step(5'b00000, 5'b00000, 1'b1);
    for (int i = 0; i < 8; i++) step(5'b00000, 5'b00000, 1'b1);
    check("timeout_pulse", tmo_a, 1);
    step(5'b11111, 5'b00000, 1'b1);
    check("after_tmo_idle", sel_a, 7);
    step(5'b11111, 5'b00000, 1'b1);
    check("after_tmo_grant_e", sel_a, 3);

    // Reset while L is locked after two flits.
    do_reset();
    step(5'b10000, 5'b00000, 1'b1);
    step(5'b10000, 5'b00000, 1'b1);
    step(5'b10000, 5'b00000, 1'b1);
    check("l_two_flits_cnt", cnt_a, 1);
    do_reset();
    step(5'b10001, 5'b00000, 1'b1);
    step(5'b10001, 5'b00000, 1'b1);
    check("post_reset_grant_n", sel_a, 1);

    // 17 single-flit transfers wrap the 4-bit counter.
    do_reset();
    for (int i = 0; i < 34; i++) step(5'b11111, 5'b11111, 1'b1);
    step(5'b00000, 5'b00000, 1'b0);
    check("cnt_wrap_a", cnt_a, 1);
    check("cnt_nowrap_b", cnt_b, 17);

    // Randomized traffic against the model, alternating heavy and light backpressure.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int rdy_pct;
      logic [4:0] r, t;
      rdy_pct = ((i / 400) % 2 == 0) ? 85 : 15;
      r = 5'($urandom_range(0, 31));
      t = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
      step(r, t, ($urandom_range(0, 99) < rdy_pct));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "bench time limit");
  end

endmodule
